// File: rtl/div_freq_meter.sv
// Period/high-time meter for the divider output; DUTY_CHECK_EN adds a registered duty_err flag.
// Result lands 2 cycles after an f_in rise; a result arriving while one is unaccepted is dropped (sticky drop).
module div_freq_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             f_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             mismatch,
    output logic             overflow,
    output logic             drop,
    output logic             duty_err
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             f_d1_q, f_d1_d, f_d2_q, f_d2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d;
    logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
    logic             valid_q, valid_d, mismatch_q, mismatch_d;
    logic             overflow_q, overflow_d, drop_q, drop_d;

    logic             rise;
    logic             res_vld, res_mm, res_ovf;
    logic [CNT_W-1:0] res_period, res_high;
    logic             load;

    assign rise = f_d1_q & ~f_d2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        f_d1_d     = f_in;
        f_d2_d     = f_d1_q;
        res_vld    = 1'b0;
        res_period = cnt_q;
        res_high   = hi_q;
        res_mm     = 1'b0;
        res_ovf    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    hi_d    = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEAS;
                        cnt_d   = CNT_ONE;
                        hi_d    = CNT_ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        res_vld = 1'b1;
                        res_mm  = (exp_period != '0) && (cnt_q != exp_period);
                        cnt_d   = CNT_ONE;
                        hi_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // Saturated with no edge: report and re-arm instead of wrapping.
                        res_vld = 1'b1;
                        res_ovf = 1'b1;
                        res_mm  = (exp_period != '0);
                        state_d = ARM;
                        cnt_d   = '0;
                        hi_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (f_d1_q) hi_d = hi_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign load = res_vld && (!valid_q || meas_ready);

    always_comb begin
        period_d    = period_q;
        high_time_d = high_time_q;
        mismatch_d  = mismatch_q;
        overflow_d  = overflow_q;
        valid_d     = valid_q;
        drop_d      = drop_q;
        if (load) begin
            period_d    = res_period;
            high_time_d = res_high;
            mismatch_d  = res_mm;
            overflow_d  = res_ovf;
            valid_d     = 1'b1;
        end else if (res_vld) begin
            drop_d = 1'b1;
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            f_d1_q      <= 1'b0;
            f_d2_q      <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_d1_q      <= f_d1_d;
            f_d2_q      <= f_d2_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = valid_q;
    assign mismatch   = mismatch_q;
    assign overflow   = overflow_q;
    assign drop       = drop_q;

`ifdef DUTY_CHECK_EN
    logic [CNT_W:0] twice_hi, per_ext, duty_diff;
    logic           duty_err_q, duty_err_d, res_duty;

    // |2*high_time - period| > 1, never flagged on a saturated measurement.
    always_comb begin
        twice_hi  = {res_high, 1'b0};
        per_ext   = {1'b0, res_period};
        duty_diff = (twice_hi >= per_ext) ? (twice_hi - per_ext) : (per_ext - twice_hi);
        res_duty  = !res_ovf && (duty_diff > {{CNT_W{1'b0}}, 1'b1});
        duty_err_d = load ? res_duty : duty_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) duty_err_q <= 1'b0;
        else       duty_err_q <= duty_err_d;
    end

    assign duty_err = duty_err_q;
`else
    assign duty_err = 1'b0;
`endif

endmodule
